// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter in front of a single-port data memory.
// Requester 0 is the CPU, requester 1 is DMA/debug. Each access takes a fixed
// three cycles: grant (IDLE), memory access (ACC), response (RSP).
// Optional build macro DMEM_ARB_RR_EN: when defined, simultaneous requests are
// arbitrated round robin; when undefined, requester 0 always wins.
module dmem_arbiter #(
  parameter int DMEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [1:0]  m0_size,
  input  logic        m0_lu,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [1:0]  m1_size,
  input  logic        m1_lu,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic [1:0]  mem_lwhb,
  output logic [1:0]  mem_swhb,
  output logic        mem_lu,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, RSP = 2'd2} state_t;

  // Extra bit so the range check stays correct even for a 4 GiB memory.
  localparam logic [32:0] ADDR_LIMIT = 33'(DMEM_BYTES);

  state_t      state;
  state_t      state_next;

  logic        grant_vld;
  logic        grant_sel;

  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [1:0]  sel_size;
  logic        sel_lu;
  logic        sel_err;

  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [1:0]  cap_size;
  logic        cap_lu;
  logic        cap_err;
  logic        cap_sel;
  logic [31:0] rsp_data;

`ifdef DMEM_ARB_RR_EN
  logic        last_gnt;
`endif

  // Pick the winner among active requests; a grant can only happen in IDLE.
  always_comb begin
    grant_vld = (state == IDLE) && (m0_req || m1_req) && !reset;
    grant_sel = 1'b0;
    if (m0_req && m1_req) begin
`ifdef DMEM_ARB_RR_EN
      grant_sel = ~last_gnt;
`else
      grant_sel = 1'b0;
`endif
    end else if (m1_req) begin
      grant_sel = 1'b1;
    end
  end

  // Route the winning request's fields and classify it as erroneous or not.
  always_comb begin
    sel_we    = grant_sel ? m1_we    : m0_we;
    sel_addr  = grant_sel ? m1_addr  : m0_addr;
    sel_wdata = grant_sel ? m1_wdata : m0_wdata;
    sel_size  = grant_sel ? m1_size  : m0_size;
    sel_lu    = grant_sel ? m1_lu    : m0_lu;
    sel_err   = (sel_size == 2'b00) ||
                ({1'b0, sel_addr} >= ADDR_LIMIT) ||
                ((sel_size == 2'b10) && sel_addr[0]) ||
                ((sel_size == 2'b11) && (sel_addr[1:0] != 2'b00));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: the access sequence never stalls once granted.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = grant_vld ? ACC : IDLE;
      ACC:     state_next = RSP;
      RSP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the granted request, latch the read data leaving ACC, track last grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_size  <= 2'b00;
      cap_lu    <= 1'b0;
      cap_err   <= 1'b0;
      cap_sel   <= 1'b0;
      rsp_data  <= '0;
`ifdef DMEM_ARB_RR_EN
      last_gnt  <= 1'b1;
`endif
    end else begin
      if (grant_vld) begin
        cap_we    <= sel_we;
        cap_addr  <= sel_addr;
        cap_wdata <= sel_wdata;
        cap_size  <= sel_size;
        cap_lu    <= sel_lu;
        cap_err   <= sel_err;
        cap_sel   <= grant_sel;
`ifdef DMEM_ARB_RR_EN
        last_gnt  <= grant_sel;
`endif
      end
      if (state == ACC) begin
        rsp_data <= (cap_we || cap_err) ? 32'h0 : mem_rd;
      end
    end
  end

  // Drive grant, memory and response outputs; everything idles at 0 during reset.
  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    m0_err    = 1'b0;
    m1_err    = 1'b0;
    mem_we    = 1'b0;
    mem_a     = '0;
    mem_wd    = '0;
    mem_lwhb  = 2'b00;
    mem_swhb  = 2'b00;
    mem_lu    = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          m0_gnt = grant_vld && !grant_sel;
          m1_gnt = grant_vld && grant_sel;
        end
        ACC: begin
          mem_we   = cap_we && !cap_err;
          mem_a    = cap_addr;
          mem_wd   = cap_wdata;
          mem_lu   = cap_lu;
          mem_lwhb = cap_we ? 2'b00 : cap_size;
          mem_swhb = cap_we ? cap_size : 2'b00;
        end
        RSP: begin
          if (cap_sel) begin
            m1_rvalid = 1'b1;
            m1_rdata  = rsp_data;
            m1_err    = cap_err;
          end else begin
            m0_rvalid = 1'b1;
            m0_rdata  = rsp_data;
            m0_err    = cap_err;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a
// byte-addressed little-endian memory model behind the memory port.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m0_lu, m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [1:0]  m0_size;
  logic        m1_req, m1_we, m1_lu, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [1:0]  m1_size;
  logic        mem_we, mem_lu;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic [1:0]  mem_lwhb, mem_swhb;

  int checks = 0;
  int failures = 0;
  int weCount = 0;
  int cyc = 0;

  logic [7:0]  mem [0:4095];
  logic [11:0] i0, i1, i2, i3;

  dmem_arbiter #(.DMEM_BYTES(4096)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_size(m0_size), .m0_lu(m0_lu), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_size(m1_size), .m1_lu(m1_lu), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_lwhb(mem_lwhb),
    .mem_swhb(mem_swhb), .mem_lu(mem_lu), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign i0 = mem_a[11:0];
  assign i1 = i0 + 12'd1;
  assign i2 = i0 + 12'd2;
  assign i3 = i0 + 12'd3;

  // Combinational memory read with size selection and sign/zero extension.
  always_comb begin
    mem_rd = 32'h0;
    case (mem_lwhb)
      2'b01: mem_rd = mem_lu ? {24'h0, mem[i0]} : {{24{mem[i0][7]}}, mem[i0]};
      2'b10: mem_rd = mem_lu ? {16'h0, mem[i1], mem[i0]}
                             : {{16{mem[i1][7]}}, mem[i1], mem[i0]};
      2'b11: mem_rd = {mem[i3], mem[i2], mem[i1], mem[i0]};
      default: mem_rd = 32'h0;
    endcase
  end

  // Synchronous memory write and write-strobe counting.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      weCount <= weCount + 1;
      mem[i0] <= mem_wd[7:0];
      if (mem_swhb[1]) mem[i1] <= mem_wd[15:8];
      if (mem_swhb == 2'b11) begin
        mem[i2] <= mem_wd[23:16];
        mem[i3] <= mem_wd[31:24];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic setReq(input int m, input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input logic lu);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_size = size; m0_lu = lu;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_size = size; m1_lu = lu;
    end
  endtask

  function automatic logic gntOf(input int m);
    return (m == 0) ? m0_gnt : m1_gnt;
  endfunction
  function automatic logic rvalidOf(input int m);
    return (m == 0) ? m0_rvalid : m1_rvalid;
  endfunction
  function automatic logic errOf(input int m);
    return (m == 0) ? m0_err : m1_err;
  endfunction
  function automatic logic [31:0] rdataOf(input int m);
    return (m == 0) ? m0_rdata : m1_rdata;
  endfunction

  // One complete access by requester m with hand-computed response.
  task automatic applyStimulus(input string tag, input int m, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [1:0] size, input logic lu,
                               input logic [31:0] expRdata, input logic expErr);
    logic got;
    int startWe;
    got = 1'b0;
    @(negedge clk);
    setReq(m, 1'b1, we, addr, wdata, size, lu);
    for (int i = 0; i < 8; i++) begin
      #1;
      if (gntOf(m)) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput({tag, " gnt"}, 32'(got), 32'd1);
    if (got) begin
      checkOutput({tag, " other gnt"}, 32'(gntOf(1 - m)), 32'd0);
      startWe = weCount;
      @(negedge clk);
      setReq(m, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
      checkOutput({tag, " acc rvalid"}, 32'(rvalidOf(m)), 32'd0);
      checkOutput({tag, " acc mem_we"}, 32'(mem_we), 32'(we && !expErr));
      checkOutput({tag, " acc mem_a"}, mem_a, addr);
      checkOutput({tag, " acc strobes"}, {28'h0, mem_swhb, mem_lwhb},
                  we ? {28'h0, size, 2'b00} : {28'h0, 2'b00, size});
      @(negedge clk);
      checkOutput({tag, " rvalid"}, 32'(rvalidOf(m)), 32'd1);
      checkOutput({tag, " rdata"}, rdataOf(m), expRdata);
      checkOutput({tag, " err"}, 32'(errOf(m)), 32'(expErr));
      checkOutput({tag, " other rvalid"}, 32'(rvalidOf(1 - m)), 32'd0);
      checkOutput({tag, " other rdata"}, rdataOf(1 - m), 32'h0);
      checkOutput({tag, " writes"}, 32'(weCount - startWe), (we && !expErr) ? 32'd1 : 32'd0);
    end else begin
      setReq(m, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    end
  endtask

  initial begin
    logic got;
    int startWe;
    int lastCyc;
    int who;
    int expWho;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    reset = 1'b1;
    setReq(0, 1'b1, 1'b1, 32'h10, 32'h55, 2'b11, 1'b0);
    setReq(1, 1'b1, 1'b1, 32'h14, 32'h66, 2'b11, 1'b0);

    // Requests held during reset must not be granted.
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset m0_gnt", 32'(m0_gnt), 32'd0);
    checkOutput("reset m1_gnt", 32'(m1_gnt), 32'd0);
    checkOutput("reset mem_we", 32'(mem_we), 32'd0);
    checkOutput("reset mem_a", mem_a, 32'h0);
    checkOutput("reset m0_rvalid", 32'(m0_rvalid), 32'd0);
    checkOutput("reset m1_rdata", m1_rdata, 32'h0);
    reset = 1'b0;
    setReq(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    setReq(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);

    // Word store/load round trip and extension cases.
    applyStimulus("st w 0x10", 0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b11, 1'b0, 32'h0, 1'b0);
    applyStimulus("ld w 0x10", 0, 1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 32'hDEADBEEF, 1'b0);
    applyStimulus("ld h 0x10 s", 0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hFFFFBEEF, 1'b0);
    applyStimulus("ld h 0x10 u", 0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b1, 32'h0000BEEF, 1'b0);
    applyStimulus("m1 ld b 0x13", 1, 1'b0, 32'h13, 32'h0, 2'b01, 1'b0, 32'hFFFFFFDE, 1'b0);
    applyStimulus("m1 ld h 0x12", 1, 1'b0, 32'h12, 32'h0, 2'b10, 1'b0, 32'hFFFFDEAD, 1'b0);

    // Misaligned store is rejected and leaves memory intact.
    applyStimulus("m1 st h 0x13", 1, 1'b1, 32'h13, 32'h0000AAAA, 2'b10, 1'b0, 32'h0, 1'b1);
    applyStimulus("ld w after err", 0, 1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 32'hDEADBEEF, 1'b0);

    // Byte load sign versus zero extension.
    applyStimulus("st w 0x30", 0, 1'b1, 32'h30, 32'h000000F0, 2'b11, 1'b0, 32'h0, 1'b0);
    applyStimulus("ld b 0x30 s", 0, 1'b0, 32'h30, 32'h0, 2'b01, 1'b0, 32'hFFFFFFF0, 1'b0);
    applyStimulus("ld b 0x30 u", 0, 1'b0, 32'h30, 32'h0, 2'b01, 1'b1, 32'h000000F0, 1'b0);

    // Range boundary and other error classes.
    applyStimulus("m1 st w 0xFFC", 1, 1'b1, 32'hFFC, 32'hCAFEF00D, 2'b11, 1'b0, 32'h0, 1'b0);
    applyStimulus("m1 ld w 0xFFC", 1, 1'b0, 32'hFFC, 32'h0, 2'b11, 1'b0, 32'hCAFEF00D, 1'b0);
    applyStimulus("ld w 0x1000", 0, 1'b0, 32'h1000, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1);
    applyStimulus("ld size00", 0, 1'b0, 32'h10, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1);
    applyStimulus("ld w 0x12", 0, 1'b0, 32'h12, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1);

    // Reset during the access cycle of a store aborts it.
    applyStimulus("st w 0x20", 0, 1'b1, 32'h20, 32'h11111111, 2'b11, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    setReq(0, 1'b1, 1'b1, 32'h20, 32'h12345678, 2'b11, 1'b0);
    #1;
    checkOutput("abort gnt", 32'(m0_gnt), 32'd1);
    startWe = weCount;
    @(negedge clk);
    setReq(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("abort mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort rvalid", 32'(m0_rvalid), 32'd0);
    setReq(0, 1'b1, 1'b0, 32'h20, 32'h0, 2'b11, 1'b0);
    #1;
    checkOutput("post reset gnt", 32'(m0_gnt), 32'd1);
    @(negedge clk);
    setReq(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    @(negedge clk);
    checkOutput("post reset rvalid", 32'(m0_rvalid), 32'd1);
    checkOutput("post reset rdata", m0_rdata, 32'h11111111);
    checkOutput("abort writes", 32'(weCount - startWe), 32'd0);

    // Contention: both requesters load continuously for four grants.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    setReq(0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b11, 1'b0);
    setReq(1, 1'b1, 1'b0, 32'h30, 32'h0, 2'b11, 1'b1);
    lastCyc = 0;
    for (int g = 0; g < 4; g++) begin
      got = 1'b0;
      for (int i = 0; i < 8; i++) begin
        #1;
        if (m0_gnt || m1_gnt) begin
          got = 1'b1;
          break;
        end
        @(negedge clk);
      end
      checkOutput($sformatf("rr grant %0d seen", g), 32'(got), 32'd1);
      if (got) begin
`ifdef DMEM_ARB_RR_EN
        expWho = g % 2;
`else
        expWho = 0;
`endif
        who = m1_gnt ? 1 : 0;
        checkOutput($sformatf("rr grant %0d who", g), 32'(who), 32'(expWho));
        checkOutput($sformatf("rr grant %0d both", g), 32'(m0_gnt && m1_gnt), 32'd0);
        if (g > 0) checkOutput($sformatf("rr grant %0d gap", g), 32'(cyc - lastCyc), 32'd3);
        lastCyc = cyc;
        @(negedge clk);
        checkOutput($sformatf("rr acc %0d gnt", g), {30'h0, m1_gnt, m0_gnt}, 32'h0);
        @(negedge clk);
        checkOutput($sformatf("rr rsp %0d rvalid", g), 32'(rvalidOf(who)), 32'd1);
        checkOutput($sformatf("rr rsp %0d rdata", g), rdataOf(who),
                    (who == 0) ? 32'hDEADBEEF : 32'h000000F0);
        @(negedge clk);
      end
    end
    setReq(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    setReq(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DMEM_BYTES, default 4096, meaning the byte size of the data memory; addresses at or above this value are out of range.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports m0_req/m1_req, input, 1 bit each: requester 0 (CPU) and requester 1 (DMA/debug) request an access.
REQ-005 SHALL have ports m0_we/m1_we, input, 1 bit each: 1 = store, 0 = load.
REQ-006 SHALL have ports m0_addr/m1_addr, input, 32 bits each: byte address.
REQ-007 SHALL have ports m0_wdata/m1_wdata, input, 32 bits each: store data, right-aligned.
REQ-008 SHALL have ports m0_size/m1_size, input, 2 bits each: 01 byte, 10 halfword, 11 word, 00 invalid.
REQ-009 SHALL have ports m0_lu/m1_lu, input, 1 bit each: 1 = zero-extend loads, 0 = sign-extend.
REQ-010 SHALL have outputs m0_gnt/m1_gnt (1), m0_rvalid/m1_rvalid (1), m0_rdata/m1_rdata (32), m0_err/m1_err (1) per requester.
REQ-011 SHALL have memory-side outputs mem_we (1), mem_a (32), mem_wd (32), mem_lwhb (2), mem_swhb (2), mem_lu (1), and input mem_rd (32), matching the dmem port set.

Function
REQ-012 SHALL implement FSM states IDLE, ACC, RSP; transitions IDLE->ACC on grant, ACC->RSP always, RSP->IDLE always.
REQ-013 SHALL, in IDLE with any req high, assert exactly one gnt for one cycle and capture that requester's we/addr/wdata/size/lu into internal registers on the same edge.
REQ-014 SHALL, with both req high in IDLE, grant the requester not granted last (round robin; last-grant pointer resets to 1 so m0 wins first).
REQ-015 SHALL ignore req in ACC and RSP; a requester holds req until it sees gnt and may drop it afterwards.
REQ-016 SHALL, in ACC only, drive mem_a/mem_wd/mem_lu from the captured registers, with mem_lwhb = size for loads (else 00) and mem_swhb = size for stores (else 00).
REQ-017 SHALL drive mem_we = (state==ACC) & captured we & !err & !reset; all other memory outputs are 0 outside ACC.
REQ-018 SHALL register mem_rd at the end of ACC and present it on the granted requester's rdata with rvalid high for exactly the RSP cycle; stores also get rvalid with rdata = 0.
REQ-019 SHALL flag err (captured at grant, shown with rvalid in RSP) when size=00, addr >= DMEM_BYTES, halfword with addr[0]=1, or word with addr[1:0]!=00.
REQ-020 SHALL, for an errored access, suppress mem_we and return rdata = 0.
REQ-021 SHALL keep non-granted requester outputs (gnt, rvalid, err, rdata) at 0.
REQ-022 SHALL give a fixed latency: gnt in cycle N, memory access in N+1, rvalid in N+2; next grant no earlier than N+3.

Reset
REQ-023 SHALL, while reset is high, force state IDLE, all gnt/rvalid/err/mem_we low, all rdata and memory outputs 0, and the last-grant pointer to 1.
REQ-024 SHALL abort any in-flight access when reset is asserted mid-operation (no write in ACC, no rvalid) and accept new requests on the first cycle after reset deasserts.

Configuration
REQ-025 SHALL support macro DMEM_ARB_RR_EN: when defined, arbitration is round robin per REQ-014; when undefined, m0 has fixed priority whenever both req are high, and the pointer is unused.

Verification
REQ-026 m0 store word 0xDEADBEEF at 0x10, then m0 load word at 0x10 -> mem_we=1 exactly one cycle; load rvalid at grant+2 with rdata 0xDEADBEEF, err=0.
REQ-027 m0 and m1 both request loads continuously for 4 grants -> grant order m0,m1,m0,m1 with DMEM_ARB_RR_EN; m0,m0,m0,m0 without it.
REQ-028 m1 store halfword at 0x13 -> m1_err=1 with rvalid, mem_we never asserted, memory contents unchanged.
REQ-029 m0 load at 0x1000 (DMEM_BYTES=4096) -> m0_err=1, m0_rdata=0.
REQ-030 reset pulsed during ACC of a store of 0x12345678 to 0x20 -> no write, no rvalid; subsequent load at 0x20 returns the prior value.
REQ-031 m0 load byte (lu=0) of stored 0x000000F0 -> rdata 0xFFFFFFF0; same with lu=1 -> 0x000000F0.
